// File: rtl/alu_writeback_pkg.sv
// Shared processor definitions: datapath defaults, status flag bit positions
// and the writeback sequencer state encoding.
package alu_writeback_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int AW_DEF     = 3;
    localparam int RETIRED_W  = 16;

    localparam int FLAG_ZA = 4;
    localparam int FLAG_ZB = 3;
    localparam int FLAG_EQ = 2;
    localparam int FLAG_GT = 1;
    localparam int FLAG_LT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wb_state_e;

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-result handshake and register-file write bus seen by the writeback stage.
interface alu_writeback_if
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*DATA_W-1:0]    in_result;
    logic [4:0]             in_flags;
    logic                   in_flags_en;
    logic [AW-1:0]          in_dest;
    logic                   in_wide;

    logic                   rf_we;
    logic [AW-1:0]          rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic [4:0]             status;
    logic                   busy;
    logic [AW-1:0]          pend_dest;
    logic [RETIRED_W-1:0]   retired;

    modport master (
        output in_valid, in_result, in_flags, in_flags_en, in_dest, in_wide,
        input  in_ready, rf_we, rf_waddr, rf_wdata, status, busy, pend_dest, retired
    );

    modport slave (
        input  in_valid, in_result, in_flags, in_flags_en, in_dest, in_wide,
        output in_ready, rf_we, rf_waddr, rf_wdata, status, busy, pend_dest, retired
    );

endinterface

// File: rtl/alu_writeback.sv
// Writeback sequencer: captures one ALU result per handshake and writes it to
// the register file as one (narrow) or two (wide, low then high) word writes.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    alu_writeback_if.slave   bus
);

    wb_state_e              state, state_nxt;

    logic [2*DATA_W-1:0]    res_p0;
    logic [AW-1:0]          dest_p0;
    logic                   wide_p0;
    logic                   fen_p0;
    logic [4:0]             flags_p0;

    logic [4:0]             status_q;
    logic [RETIRED_W-1:0]   retired_q;

    logic                   ready;
    logic                   hs;
    logic                   last_wr;
    logic                   we;
    logic [AW-1:0]          waddr;
    logic [DATA_W-1:0]      wdata;

    function automatic logic [RETIRED_W-1:0] sat_inc(input logic [RETIRED_W-1:0] v);
        return (v == '1) ? v : v + RETIRED_W'(1);
    endfunction

    // A new result may arrive whenever the current cycle is the last write of its sequence.
    assign ready = !rst && ((state == IDLE) || (state == WR_HI) ||
                            ((state == WR_LO) && !wide_p0));
    assign hs    = bus.in_valid && ready;

    always_comb begin
        state_nxt = state;
        last_wr   = 1'b0;
        we        = 1'b0;
        waddr     = '0;
        wdata     = '0;
        unique case (state)
            IDLE: begin
                if (hs) state_nxt = WR_LO;
            end
            WR_LO: begin
                we    = 1'b1;
                waddr = dest_p0;
                wdata = res_p0[DATA_W-1:0];
                if (wide_p0) begin
                    state_nxt = WR_HI;
                end else begin
                    last_wr   = 1'b1;
                    state_nxt = hs ? WR_LO : IDLE;
                end
            end
            WR_HI: begin
                we        = 1'b1;
                waddr     = dest_p0 + AW'(1);
                wdata     = res_p0[2*DATA_W-1:DATA_W];
                last_wr   = 1'b1;
                state_nxt = hs ? WR_LO : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: capture stage, reloaded on every handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            res_p0   <= '0;
            dest_p0  <= '0;
            wide_p0  <= 1'b0;
            fen_p0   <= 1'b0;
            flags_p0 <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                res_p0   <= bus.in_result;
                dest_p0  <= bus.in_dest;
                wide_p0  <= bus.in_wide;
                fen_p0   <= bus.in_flags_en;
                flags_p0 <= bus.in_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= '0;
            retired_q <= '0;
        end else begin
            if ((state == WR_LO) && fen_p0) status_q <= flags_p0;
            if (last_wr) retired_q <= sat_inc(retired_q);
        end
    end

    assign bus.in_ready  = ready;
    assign bus.rf_we     = we;
    assign bus.rf_waddr  = waddr;
    assign bus.rf_wdata  = wdata;
    assign bus.status    = status_q;
    assign bus.busy      = (state != IDLE);
    assign bus.pend_dest = (state != IDLE) ? dest_p0 : '0;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus random traffic, all checked
// against a queue-of-pending-writes reference model.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int AW = AW_DEF;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW-1:0] dest;
        logic          first;
        logic          last;
        logic          fen;
        logic [4:0]    flags;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_writeback_if #(.DATA_W(DW), .AW(AW)) bus ();

    alu_writeback #(.DATA_W(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t        q[$];
    logic [4:0] m_status = '0;
    int         m_retired = 0;
    int         total = 0;
    int         bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return !rst && (q.size() <= 1);
    endfunction

    // One clock cycle: check ready, advance the model across the edge, check outputs.
    task automatic tick();
        logic hs;
        logic wide;
        wr_t  lo, hi, e;
        #1;
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
        hs   = bus.in_valid && exp_ready();
        wide = bus.in_wide;
        lo.addr = bus.in_dest;        lo.data = bus.in_result[DW-1:0];
        lo.dest = bus.in_dest;        lo.first = 1'b1;  lo.last = !bus.in_wide;
        lo.fen  = bus.in_flags_en;    lo.flags = bus.in_flags;
        hi = lo;
        hi.addr  = AW'((int'(bus.in_dest) + 1) % (1 << AW));
        hi.data  = bus.in_result[2*DW-1:DW];
        hi.first = 1'b0;
        hi.last  = 1'b1;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_status  = '0;
            m_retired = 0;
        end else begin
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.first && e.fen) m_status = e.flags;
                if (e.last && m_retired < 65535) m_retired++;
            end
            if (hs) begin
                q.push_back(lo);
                if (wide) q.push_back(hi);
            end
        end
        #1;
        if (q.size() > 0) begin
            check("rf_we", 32'(bus.rf_we), 32'd1);
            check("rf_waddr", 32'(bus.rf_waddr), 32'(q[0].addr));
            check("rf_wdata", 32'(bus.rf_wdata), 32'(q[0].data));
            check("busy", 32'(bus.busy), 32'd1);
            check("pend_dest", 32'(bus.pend_dest), 32'(q[0].dest));
        end else begin
            check("rf_we", 32'(bus.rf_we), 32'd0);
            check("rf_waddr", 32'(bus.rf_waddr), 32'd0);
            check("rf_wdata", 32'(bus.rf_wdata), 32'd0);
            check("busy", 32'(bus.busy), 32'd0);
            check("pend_dest", 32'(bus.pend_dest), 32'd0);
        end
        check("status", 32'(bus.status), 32'(m_status));
        check("retired", 32'(bus.retired), 32'(m_retired));
    endtask

    task automatic set_in(input logic v, input logic [2*DW-1:0] r, input logic [AW-1:0] d,
                          input logic w, input logic fe, input logic [4:0] f);
        bus.in_valid    = v;
        bus.in_result   = r;
        bus.in_dest     = d;
        bus.in_wide     = w;
        bus.in_flags_en = fe;
        bus.in_flags    = f;
    endtask

    task automatic idle_in();
        set_in(1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        check("rst_we", 32'(bus.rf_we), 32'd0);
        check("rst_retired", 32'(bus.retired), 32'd0);
        rst = 1'b0;
        tick();

        // narrow write
        set_in(1'b1, 32'h0000_0011, 3'd2, 1'b0, 1'b1, 5'b00010);
        tick();
        idle_in();
        check("narrow_we", 32'(bus.rf_we), 32'd1);
        check("narrow_addr", 32'(bus.rf_waddr), 32'd2);
        check("narrow_data", 32'(bus.rf_wdata), 32'h0011);
        tick();
        check("narrow_status", 32'(bus.status), 32'b00010);
        check("narrow_retired", 32'(bus.retired), 32'd1);

        // wide write
        set_in(1'b1, 32'h1234_ABCD, 3'd4, 1'b1, 1'b0, 5'b11111);
        tick();
        idle_in();
        check("wide_lo_addr", 32'(bus.rf_waddr), 32'd4);
        check("wide_lo_data", 32'(bus.rf_wdata), 32'hABCD);
        check("wide_lo_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("wide_hi_addr", 32'(bus.rf_waddr), 32'd5);
        check("wide_hi_data", 32'(bus.rf_wdata), 32'h1234);
        tick();

        // wrap-around of the high-half address
        set_in(1'b1, 32'hBEEF_0007, 3'd7, 1'b1, 1'b0, 5'b0);
        tick();
        idle_in();
        tick();
        check("wrap_addr", 32'(bus.rf_waddr), 32'd0);
        check("wrap_data", 32'(bus.rf_wdata), 32'hBEEF);
        tick();

        // back-to-back narrow, from a fresh counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(32'h100 + i), AW'(i), 1'b0, 1'b0, 5'b0);
            tick();
            check("b2b_we", 32'(bus.rf_we), 32'd1);
            check("b2b_data", 32'(bus.rf_wdata), 32'(32'h100 + i));
        end
        idle_in();
        tick();
        check("b2b_retired", 32'(bus.retired), 32'd4);

        // reset during the low write of a wide op
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(1'b1, 32'hCAFE_F00D, 3'd1, 1'b1, 1'b1, 5'b10101);
        tick();
        idle_in();
        check("abort_lo_we", 32'(bus.rf_we), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_we", 32'(bus.rf_we), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_status", 32'(bus.status), 32'd0);
        check("abort_retired", 32'(bus.retired), 32'd0);
        tick();
        check("abort_no_hi", 32'(bus.rf_we), 32'd0);

        // flags hold when flags_en=0
        set_in(1'b1, 32'h0000_0055, 3'd3, 1'b0, 1'b1, 5'b10101);
        tick();
        set_in(1'b1, 32'h0000_0066, 3'd6, 1'b0, 1'b0, 5'b01010);
        tick();
        idle_in();
        check("hold_we", 32'(bus.rf_we), 32'd1);
        check("hold_data", 32'(bus.rf_wdata), 32'h0066);
        tick();
        check("hold_status", 32'(bus.status), 32'b10101);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_in($urandom_range(0, 9) < 6, (2*DW)'($urandom), AW'($urandom),
                   1'($urandom), 1'($urandom), 5'($urandom));
            tick();
        end
        rst = 1'b0;
        idle_in();
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
